// File: rtl/control_sequencer.sv
// -----------------------------------------------------------------------------
// control_sequencer
//
// Purpose:
//   Instruction sequencer for a small accumulator machine. It steps
//   FETCH -> DECODE -> EXEC (-> WB for ALU ops) and decodes the control
//   strobes for the datapath from the registered state and the IR opcode.
//   It also counts retired instructions and parks in HALT on HLT.
//
// State table:
//   state  | code | meaning
//   IDLE   | 000  | out of reset, waiting for Run (level)
//   FETCH  | 001  | load IR, increment PC
//   DECODE | 010  | opcode settles; HLT branches to HALT
//   EXEC   | 011  | per-opcode datapath action
//   WB     | 100  | ALU result written into accumulator
//   HALT   | 101  | stopped, waiting for a Run rising edge
//   (110/111 are unreachable and recover to IDLE on the next edge)
//
// Ports:
//   CLK        in   system clock, rising edge
//   CLB        in   asynchronous active-high reset
//   Run        in   start/resume request (IDLE: level, HALT: rising edge)
//   Opcode     in   [3:0] IR opcode field
//   Zero       in   accumulator-zero flag (for JZ)
//   LoadIR     out  IR load enable
//   IncPC      out  PC increment
//   LoadPC     out  PC load from immediate
//   LoadAcc    out  accumulator load enable
//   SelImm     out  accumulator source: 1 immediate, 0 ALU
//   AluOp      out  [1:0] 00 ADD, 01 SUB, 10 AND, 11 OR
//   RegWrite   out  register-file write of accumulator
//   Halted     out  sequencer is in HALT
//   State      out  [2:0] current state code
//   InstrCount out  [7:0] retired-instruction counter, wraps
// -----------------------------------------------------------------------------
module control_sequencer (
    input  logic       CLK,
    input  logic       CLB,
    input  logic       Run,
    input  logic [3:0] Opcode,
    input  logic       Zero,
    output logic       LoadIR,
    output logic       IncPC,
    output logic       LoadPC,
    output logic       LoadAcc,
    output logic       SelImm,
    output logic [1:0] AluOp,
    output logic       RegWrite,
    output logic       Halted,
    output logic [2:0] State,
    output logic [7:0] InstrCount
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'b000,
        S_FETCH  = 3'b001,
        S_DECODE = 3'b010,
        S_EXEC   = 3'b011,
        S_WB     = 3'b100,
        S_HALT   = 3'b101
    } state_t;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDI = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_AND = 4'h4;
    localparam logic [3:0] OP_OR  = 4'h5;
    localparam logic [3:0] OP_STA = 4'h6;
    localparam logic [3:0] OP_JMP = 4'h7;
    localparam logic [3:0] OP_JZ  = 4'h8;
    localparam logic [3:0] OP_HLT = 4'hF;

    state_t     state_q, state_d;
    logic       run_prev_q;
    logic [7:0] instr_count_q, instr_count_d;

    logic       is_alu;
    logic [1:0] alu_sel;
    logic       retire;
    logic       run_rise;

    // ADD..OR are contiguous opcodes; AluOp is simply the offset from ADD.
    always_comb begin
        is_alu  = 1'b0;
        alu_sel = 2'b00;
        case (Opcode)
            OP_ADD: begin is_alu = 1'b1; alu_sel = 2'b00; end
            OP_SUB: begin is_alu = 1'b1; alu_sel = 2'b01; end
            OP_AND: begin is_alu = 1'b1; alu_sel = 2'b10; end
            OP_OR:  begin is_alu = 1'b1; alu_sel = 2'b11; end
            default: begin is_alu = 1'b0; alu_sel = 2'b00; end
        endcase
    end

    // Run history only matters in HALT: a Run held high since before
    // halting must not restart, so HALT wants a true rising edge.
    assign run_rise = Run & ~run_prev_q;

    // ---------------------------------------------------------------------
    // State register, Run history and retired-instruction counter
    // ---------------------------------------------------------------------
    always_ff @(posedge CLK or posedge CLB) begin
        if (CLB) begin
            state_q       <= S_IDLE;
            run_prev_q    <= 1'b0;
            instr_count_q <= 8'd0;
        end else begin
            state_q       <= state_d;
            run_prev_q    <= Run;
            instr_count_q <= instr_count_d;
        end
    end

    // ---------------------------------------------------------------------
    // Next-state and control decode
    // ---------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        retire   = 1'b0;
        LoadIR   = 1'b0;
        IncPC    = 1'b0;
        LoadPC   = 1'b0;
        LoadAcc  = 1'b0;
        SelImm   = 1'b0;
        AluOp    = 2'b00;
        RegWrite = 1'b0;
        Halted   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (Run) begin
                    state_d = S_FETCH;
                end
            end

            S_FETCH: begin
                LoadIR  = 1'b1;
                IncPC   = 1'b1;
                state_d = S_DECODE;
            end

            S_DECODE: begin
                if (Opcode == OP_HLT) begin
                    state_d = S_HALT;
                    retire  = 1'b1;
                end else begin
                    state_d = S_EXEC;
                end
            end

            S_EXEC: begin
                if (is_alu) begin
                    AluOp   = alu_sel;
                    state_d = S_WB;
                end else begin
                    state_d = S_FETCH;
                    retire  = 1'b1;
                    case (Opcode)
                        OP_LDI: begin
                            LoadAcc = 1'b1;
                            SelImm  = 1'b1;
                        end
                        OP_STA: RegWrite = 1'b1;
                        OP_JMP: LoadPC   = 1'b1;
                        OP_JZ:  LoadPC   = Zero;
                        default: ;  // OP_NOP and unassigned opcodes
                    endcase
                end
            end

            // Opcode is stable in the IR through WB, so re-decoding it
            // reproduces the AluOp driven in EXEC.
            S_WB: begin
                LoadAcc = 1'b1;
                AluOp   = alu_sel;
                state_d = S_FETCH;
                retire  = 1'b1;
            end

            S_HALT: begin
                Halted = 1'b1;
                if (run_rise) begin
                    state_d = S_FETCH;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign instr_count_d = retire ? (instr_count_q + 8'd1) : instr_count_q;

    assign State      = state_q;
    assign InstrCount = instr_count_q;

    // Unused opcode labels kept for readability of the decode above.
    logic unused_ok;
    assign unused_ok = (OP_NOP == 4'h0);

endmodule

// File: tb/tb_control_sequencer.sv
module tb_control_sequencer;

    logic       CLK;
    logic       CLB;
    logic       Run;
    logic [3:0] Opcode;
    logic       Zero;
    logic       LoadIR, IncPC, LoadPC, LoadAcc, SelImm, RegWrite, Halted;
    logic [1:0] AluOp;
    logic [2:0] State;
    logic [7:0] InstrCount;

    control_sequencer dut (
        .CLK        (CLK),
        .CLB        (CLB),
        .Run        (Run),
        .Opcode     (Opcode),
        .Zero       (Zero),
        .LoadIR     (LoadIR),
        .IncPC      (IncPC),
        .LoadPC     (LoadPC),
        .LoadAcc    (LoadAcc),
        .SelImm     (SelImm),
        .AluOp      (AluOp),
        .RegWrite   (RegWrite),
        .Halted     (Halted),
        .State      (State),
        .InstrCount (InstrCount)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Control bundle order: LoadIR IncPC LoadPC LoadAcc SelImm AluOp[1:0] RegWrite Halted
    logic [8:0] ctrl;
    assign ctrl = {LoadIR, IncPC, LoadPC, LoadAcc, SelImm, AluOp, RegWrite, Halted};

    localparam logic [8:0] C_NONE  = 9'b0_0_0_0_0_00_0_0;
    localparam logic [8:0] C_FETCH = 9'b1_1_0_0_0_00_0_0;
    localparam logic [8:0] C_LDI   = 9'b0_0_0_1_1_00_0_0;
    localparam logic [8:0] C_LDPC  = 9'b0_0_1_0_0_00_0_0;
    localparam logic [8:0] C_STA   = 9'b0_0_0_0_0_00_1_0;
    localparam logic [8:0] C_HALT  = 9'b0_0_0_0_0_00_0_1;
    localparam logic [8:0] C_EADD  = 9'b0_0_0_0_0_00_0_0;
    localparam logic [8:0] C_ESUB  = 9'b0_0_0_0_0_01_0_0;
    localparam logic [8:0] C_EAND  = 9'b0_0_0_0_0_10_0_0;
    localparam logic [8:0] C_EOR   = 9'b0_0_0_0_0_11_0_0;
    localparam logic [8:0] C_WADD  = 9'b0_0_0_1_0_00_0_0;
    localparam logic [8:0] C_WSUB  = 9'b0_0_0_1_0_01_0_0;
    localparam logic [8:0] C_WAND  = 9'b0_0_0_1_0_10_0_0;
    localparam logic [8:0] C_WOR   = 9'b0_0_0_1_0_11_0_0;

    localparam logic [2:0] ST_IDLE = 3'd0, ST_FETCH = 3'd1, ST_DEC = 3'd2,
                           ST_EXEC = 3'd3, ST_WB = 3'd4, ST_HALT = 3'd5;

    typedef struct {
        logic       run;
        logic [3:0] op;
        logic       zero;
        logic [2:0] exp_state;
        logic [8:0] exp_ctrl;
        logic [7:0] exp_cnt;
    } vec_t;

    vec_t vecs[52];

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic chk_all(input string tag, input logic [2:0] s, input logic [8:0] c,
                           input logic [7:0] n);
        chk({tag, " state"}, {29'd0, State}, {29'd0, s});
        chk({tag, " ctrl"}, {23'd0, ctrl}, {23'd0, c});
        chk({tag, " count"}, {24'd0, InstrCount}, {24'd0, n});
        chk({tag, " excl"}, {31'd0, ($countones({LoadIR, LoadPC, RegWrite}) <= 1) && !(IncPC && LoadPC)},
            32'd1);
    endtask

    function automatic vec_t mk(input logic r, input logic [3:0] o, input logic z,
                                input logic [2:0] s, input logic [8:0] c, input logic [7:0] n);
        vec_t v;
        v.run = r; v.op = o; v.zero = z; v.exp_state = s; v.exp_ctrl = c; v.exp_cnt = n;
        return v;
    endfunction

    initial begin
        // Each record: inputs driven after a falling edge, expected outputs of
        // the current state; the following rising edge advances the FSM.
        vecs[0]  = mk(0, 4'h1, 0, ST_IDLE,  C_NONE,  8'd0);
        vecs[1]  = mk(1, 4'h1, 0, ST_IDLE,  C_NONE,  8'd0);
        vecs[2]  = mk(0, 4'h1, 0, ST_FETCH, C_FETCH, 8'd0);
        vecs[3]  = mk(0, 4'h1, 0, ST_DEC,   C_NONE,  8'd0);
        vecs[4]  = mk(0, 4'h1, 0, ST_EXEC,  C_LDI,   8'd0);
        vecs[5]  = mk(0, 4'h3, 0, ST_FETCH, C_FETCH, 8'd1);
        vecs[6]  = mk(0, 4'h3, 0, ST_DEC,   C_NONE,  8'd1);
        vecs[7]  = mk(0, 4'h3, 0, ST_EXEC,  C_ESUB,  8'd1);
        vecs[8]  = mk(0, 4'h3, 0, ST_WB,    C_WSUB,  8'd1);
        vecs[9]  = mk(0, 4'h8, 0, ST_FETCH, C_FETCH, 8'd2);
        vecs[10] = mk(0, 4'h8, 0, ST_DEC,   C_NONE,  8'd2);
        vecs[11] = mk(0, 4'h8, 0, ST_EXEC,  C_NONE,  8'd2);
        vecs[12] = mk(0, 4'h8, 1, ST_FETCH, C_FETCH, 8'd3);
        vecs[13] = mk(0, 4'h8, 1, ST_DEC,   C_NONE,  8'd3);
        vecs[14] = mk(0, 4'h8, 1, ST_EXEC,  C_LDPC,  8'd3);
        vecs[15] = mk(0, 4'h6, 0, ST_FETCH, C_FETCH, 8'd4);
        vecs[16] = mk(0, 4'h6, 0, ST_DEC,   C_NONE,  8'd4);
        vecs[17] = mk(0, 4'h6, 0, ST_EXEC,  C_STA,   8'd4);
        vecs[18] = mk(0, 4'h7, 0, ST_FETCH, C_FETCH, 8'd5);
        vecs[19] = mk(0, 4'h7, 0, ST_DEC,   C_NONE,  8'd5);
        vecs[20] = mk(0, 4'h7, 0, ST_EXEC,  C_LDPC,  8'd5);
        vecs[21] = mk(0, 4'h2, 0, ST_FETCH, C_FETCH, 8'd6);
        vecs[22] = mk(0, 4'h2, 0, ST_DEC,   C_NONE,  8'd6);
        vecs[23] = mk(0, 4'h2, 0, ST_EXEC,  C_EADD,  8'd6);
        vecs[24] = mk(0, 4'h2, 0, ST_WB,    C_WADD,  8'd6);
        vecs[25] = mk(0, 4'h4, 0, ST_FETCH, C_FETCH, 8'd7);
        vecs[26] = mk(0, 4'h4, 0, ST_DEC,   C_NONE,  8'd7);
        vecs[27] = mk(0, 4'h4, 0, ST_EXEC,  C_EAND,  8'd7);
        vecs[28] = mk(0, 4'h4, 0, ST_WB,    C_WAND,  8'd7);
        vecs[29] = mk(0, 4'h5, 0, ST_FETCH, C_FETCH, 8'd8);
        vecs[30] = mk(0, 4'h5, 0, ST_DEC,   C_NONE,  8'd8);
        vecs[31] = mk(0, 4'h5, 0, ST_EXEC,  C_EOR,   8'd8);
        vecs[32] = mk(0, 4'h5, 0, ST_WB,    C_WOR,   8'd8);
        vecs[33] = mk(0, 4'h9, 1, ST_FETCH, C_FETCH, 8'd9);
        vecs[34] = mk(0, 4'h9, 1, ST_DEC,   C_NONE,  8'd9);
        vecs[35] = mk(0, 4'h9, 1, ST_EXEC,  C_NONE,  8'd9);
        vecs[36] = mk(1, 4'h0, 0, ST_FETCH, C_FETCH, 8'd10);
        vecs[37] = mk(1, 4'h0, 0, ST_DEC,   C_NONE,  8'd10);
        vecs[38] = mk(1, 4'h0, 0, ST_EXEC,  C_NONE,  8'd10);
        vecs[39] = mk(0, 4'hE, 1, ST_FETCH, C_FETCH, 8'd11);
        vecs[40] = mk(0, 4'hE, 1, ST_DEC,   C_NONE,  8'd11);
        vecs[41] = mk(0, 4'hE, 1, ST_EXEC,  C_NONE,  8'd11);
        vecs[42] = mk(1, 4'hF, 0, ST_FETCH, C_FETCH, 8'd12);
        vecs[43] = mk(1, 4'hF, 0, ST_DEC,   C_NONE,  8'd12);
        vecs[44] = mk(1, 4'hF, 0, ST_HALT,  C_HALT,  8'd13);
        vecs[45] = mk(1, 4'hF, 0, ST_HALT,  C_HALT,  8'd13);
        vecs[46] = mk(0, 4'hF, 0, ST_HALT,  C_HALT,  8'd13);
        vecs[47] = mk(1, 4'hF, 0, ST_HALT,  C_HALT,  8'd13);
        vecs[48] = mk(1, 4'h1, 0, ST_FETCH, C_FETCH, 8'd13);
        vecs[49] = mk(0, 4'h1, 0, ST_DEC,   C_NONE,  8'd13);
        vecs[50] = mk(0, 4'h1, 0, ST_EXEC,  C_LDI,   8'd13);
        vecs[51] = mk(0, 4'h2, 0, ST_FETCH, C_FETCH, 8'd14);

        CLB = 1'b1; Run = 1'b0; Opcode = 4'h0; Zero = 1'b0;
        @(negedge CLK);
        chk_all("reset", ST_IDLE, C_NONE, 8'd0);
        CLB = 1'b0;

        for (int i = 0; i < 52; i++) begin
            @(negedge CLK);
            Run = vecs[i].run; Opcode = vecs[i].op; Zero = vecs[i].zero;
            #1;
            chk_all($sformatf("vec%0d", i), vecs[i].exp_state, vecs[i].exp_ctrl, vecs[i].exp_cnt);
        end

        // ADD in flight: walk to WB, then reset asynchronously before the edge.
        Run = 1'b0;
        repeat (3) @(negedge CLK);
        #1;
        chk_all("pre-reset WB", ST_WB, C_WADD, 8'd14);
        #2;
        CLB = 1'b1;
        #1;
        chk_all("async reset", ST_IDLE, C_NONE, 8'd0);
        Run = 1'b1;
        @(negedge CLK);
        #1;
        chk_all("reset held", ST_IDLE, C_NONE, 8'd0);
        Run = 1'b0;
        CLB = 1'b0;
        repeat (2) @(negedge CLK);
        #1;
        chk_all("idle no run", ST_IDLE, C_NONE, 8'd0);

        // 256 NOPs with Run held high: counter wraps to zero.
        Opcode = 4'h0;
        Run = 1'b1;
        @(negedge CLK);
        #1;
        chk_all("nop start", ST_FETCH, C_FETCH, 8'd0);
        repeat (3 * 255) @(negedge CLK);
        #1;
        chk_all("nop 255", ST_FETCH, C_FETCH, 8'd255);
        repeat (3) @(negedge CLK);
        #1;
        chk_all("nop wrap", ST_FETCH, C_FETCH, 8'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 SHALL have port CLK, input, 1 bit: single system clock, rising-edge active.
REQ-002 SHALL have port CLB, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port Run, input, 1 bit: start/resume request, sampled in IDLE and HALT.
REQ-004 SHALL have port Opcode, input, 4 bits: instruction-register opcode field, valid from the cycle after LoadIR.
REQ-005 SHALL have port Zero, input, 1 bit: accumulator-zero flag.
REQ-006 SHALL have port LoadIR, output, 1 bit: instruction-register load enable.
REQ-007 SHALL have port IncPC, output, 1 bit: program-counter increment.
REQ-008 SHALL have port LoadPC, output, 1 bit: program-counter load from Immediate.
REQ-009 SHALL have port LoadAcc, output, 1 bit: accumulator load enable.
REQ-010 SHALL have port SelImm, output, 1 bit: accumulator source is Immediate (1) or ALU (0).
REQ-011 SHALL have port AluOp, output, 2 bits: 00 ADD, 01 SUB, 10 AND, 11 OR.
REQ-012 SHALL have port RegWrite, output, 1 bit: register-file write of accumulator at RegAddress.
REQ-013 SHALL have port Halted, output, 1 bit: sequencer in HALT.
REQ-014 SHALL have port State, output, 3 bits: current state encoding, for debug.
REQ-015 SHALL have port InstrCount, output, 8 bits: retired-instruction counter.

Function
REQ-016 SHALL implement registered states IDLE=000, FETCH=001, DECODE=010, EXEC=011, WB=100, HALT=101; codes 110/111 go to IDLE on the next edge.
REQ-017 SHALL make all control outputs combinational decodes of State and Opcode (Moore/Mealy-on-Opcode); State SHALL be registered.
REQ-018 IDLE: all controls 0; Run=1 -> FETCH, else stay.
REQ-019 FETCH: LoadIR=1, IncPC=1 for exactly one cycle; -> DECODE unconditionally.
REQ-020 DECODE: all controls 0; Opcode F (HLT) -> HALT; every other opcode -> EXEC.
REQ-021 EXEC, opcode 1 (LDI): LoadAcc=1, SelImm=1; -> FETCH.
REQ-022 EXEC, opcodes 2/3/4/5 (ADD/SUB/AND/OR): AluOp=00/01/10/11, other controls 0; -> WB.
REQ-023 WB: LoadAcc=1, SelImm=0, AluOp held at the EXEC value; -> FETCH.
REQ-024 EXEC, opcode 6 (STA): RegWrite=1; -> FETCH.
REQ-025 EXEC, opcode 7 (JMP): LoadPC=1; opcode 8 (JZ): LoadPC=Zero; both -> FETCH.
REQ-026 EXEC, opcode 0 and unassigned opcodes 9-E: no controls asserted (NOP); -> FETCH.
REQ-027 Instruction latency SHALL be 4 cycles for ALU ops and 3 cycles for all others, FETCH to next FETCH.
REQ-028 InstrCount SHALL increment by 1 on each edge leaving EXEC toward FETCH, leaving WB, and entering HALT; it SHALL wrap from 255 to 0.
REQ-029 HALT: Halted=1, all other controls 0; a Run 0->1 edge (Run=1 with prior-cycle Run=0) -> FETCH; a level-high Run held since halting SHALL NOT restart.
REQ-030 Run SHALL be ignored in FETCH, DECODE, EXEC and WB.
REQ-031 At most one of LoadIR, LoadPC and RegWrite SHALL be asserted in any cycle; IncPC and LoadPC SHALL never coincide.

Reset
REQ-032 CLB=1 SHALL immediately, without a clock, force State=IDLE, InstrCount=0, the Run-history register=0, and all control outputs and Halted to 0.
REQ-033 CLB asserted in any state, including mid-instruction, SHALL abandon that instruction with no further control pulses.
REQ-034 After CLB deasserts, the first transition SHALL occur only on a rising CLK edge with Run=1.

Verification
REQ-035 Reset, then Run=1 with Opcode=1: State sequence IDLE, FETCH, DECODE, EXEC, FETCH; LoadAcc=SelImm=1 only in EXEC; InstrCount=1.
REQ-036 Opcode=3 (SUB): AluOp=01 in EXEC and WB; LoadAcc=1 only in WB; 4-cycle period; InstrCount increments once.
REQ-037 Opcode=8 with Zero=0 gives LoadPC=0; repeat with Zero=1 gives LoadPC=1 in EXEC only.
REQ-038 Opcode=F: Halted=1 after DECODE; Run held high causes no restart; Run 0 then 1 causes FETCH on the next edge.
REQ-039 Assert CLB asynchronously mid-WB: outputs 0 and State=000 before the next CLK edge; InstrCount=0.
REQ-040 Run 256 NOPs: InstrCount wraps to 0; opcode 9 produces no controls in EXEC.
